// File: rtl/fire_rx.sv
// fire_rx: IR carrier burst detector; counts bursts of correctly-spaced rising edges as "hits".
// Latency: ir_in edge -> hit_flag in 3 PCLK (2-flop sync + edge register); APB read data 1 PCLK after select.
// Backpressure: none; PREADY tied high, PSLVERR tied low, every APB access completes in its access phase.
// Ports: PCLK/PRESET clock and synchronous active-high reset; APB slave PSEL..PSLVERR decoded at
//        PADDR[11:8]==7 (reg = PADDR[3:2]); ir_in raw sensor input; hit_irq level interrupt.
module fire_rx #(
  parameter int PERIOD      = 1317,
  parameter int TOL         = 64,
  parameter int HIT_PERIODS = 8,
  parameter int GAP         = 3951
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  input  logic        ir_in,
  output logic        hit_irq
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TRACK   = 2'd1,
    LOCKOUT = 2'd2
  } state_e;

  localparam logic [12:0] PER_LO = 13'(PERIOD - TOL);
  localparam logic [12:0] PER_HI = 13'(PERIOD + TOL);
  localparam logic [12:0] GAP_N  = 13'(GAP);
  localparam logic [3:0]  HIT_N  = 4'(HIT_PERIODS);

  logic        sync1_q, sync2_q, sync3_q;
  logic        rise;
  logic [12:0] interval_q, interval_d;
  logic [12:0] last_int_q, last_int_d;
  state_e      state_q, state_d;
  logic [3:0]  vcnt_q, vcnt_d;
  logic        hit_flag_q, hit_flag_d;
  logic [7:0]  hit_cnt_q, hit_cnt_d;
  logic        enable_q, enable_d;
  logic        irq_en_q, irq_en_d;
  logic [31:0] prdata_q, prdata_d;

  logic        hit;
  logic        period_ok;
  logic        carrier_present;
  logic        blk_sel;
  logic        apb_wr;
  logic        apb_rd;
  logic [1:0]  reg_idx;
  logic        unused_ok;

  // sync3_q is the previous synchronized sample, used only for edge detection.
  assign rise            = sync2_q & ~sync3_q;
  assign period_ok       = (interval_q >= PER_LO) && (interval_q <= PER_HI);
  assign carrier_present = (state_q != IDLE);

  assign blk_sel = (PADDR[11:8] == 4'd7);
  assign reg_idx = PADDR[3:2];
  assign apb_wr  = PSEL && PENABLE && PWRITE && blk_sel;
  assign apb_rd  = PSEL && !PWRITE && blk_sel;

  assign PRDATA  = prdata_q;
  assign PREADY  = 1'b1;
  assign PSLVERR = 1'b0;
  assign hit_irq = hit_flag_q & irq_en_q;

  assign unused_ok = ^{PADDR[31:12], PADDR[7:4], PADDR[1:0], PWDATA[31:3]};

  // Burst tracking FSM. Disabling forces IDLE so a later enable starts a fresh burst.
  always_comb begin
    state_d = state_q;
    vcnt_d  = vcnt_q;
    hit     = 1'b0;
    if (!enable_q) begin
      state_d = IDLE;
      vcnt_d  = 4'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rise) begin
            state_d = TRACK;
            vcnt_d  = 4'd0;
          end
        end
        TRACK: begin
          if (rise) begin
            if (period_ok) begin
              if (4'(vcnt_q + 4'd1) == HIT_N) begin
                hit     = 1'b1;
                state_d = LOCKOUT;
                vcnt_d  = 4'd0;
              end else begin
                vcnt_d = 4'(vcnt_q + 4'd1);
              end
            end else begin
              vcnt_d = 4'd0;
            end
          end else if (interval_q >= GAP_N) begin
            state_d = IDLE;
            vcnt_d  = 4'd0;
          end
        end
        LOCKOUT: begin
          // Rises only restart the gap timer here, so a burst yields a single hit.
          if (!rise && (interval_q >= GAP_N)) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          vcnt_d  = 4'd0;
        end
      endcase
    end
  end

  // Interval measurement, register file and read mux.
  always_comb begin
    interval_d = interval_q;
    last_int_d = last_int_q;
    hit_flag_d = hit_flag_q;
    hit_cnt_d  = hit_cnt_q;
    enable_d   = enable_q;
    irq_en_d   = irq_en_q;
    prdata_d   = 32'd0;

    if (rise) begin
      interval_d = 13'd1;
      last_int_d = interval_q;
    end else if (interval_q != 13'h1FFF) begin
      interval_d = interval_q + 13'd1;
    end

    if (apb_wr && (reg_idx == 2'd0)) begin
      enable_d = PWDATA[1];
      irq_en_d = PWDATA[2];
    end

    // A new hit outranks a simultaneous write-one-to-clear.
    if (hit) begin
      hit_flag_d = 1'b1;
    end else if (apb_wr && (reg_idx == 2'd0) && PWDATA[0]) begin
      hit_flag_d = 1'b0;
    end

    // Clear and increment in the same cycle leave the count at 1.
    if (apb_wr && (reg_idx == 2'd1)) begin
      hit_cnt_d = hit ? 8'd1 : 8'd0;
    end else if (hit && (hit_cnt_q != 8'hFF)) begin
      hit_cnt_d = hit_cnt_q + 8'd1;
    end

    if (apb_rd) begin
      unique case (reg_idx)
        2'd0:    prdata_d = {26'd0, enable_q, state_q, carrier_present, irq_en_q, hit_flag_q};
        2'd1:    prdata_d = {24'd0, hit_cnt_q};
        2'd2:    prdata_d = {19'd0, last_int_q};
        default: prdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
      interval_q <= 13'd0;
      last_int_q <= 13'd0;
      state_q    <= IDLE;
      vcnt_q     <= 4'd0;
      hit_flag_q <= 1'b0;
      hit_cnt_q  <= 8'd0;
      enable_q   <= 1'b1;
      irq_en_q   <= 1'b0;
      prdata_q   <= 32'd0;
    end else begin
      sync1_q    <= ir_in;
      sync2_q    <= sync1_q;
      sync3_q    <= sync2_q;
      interval_q <= interval_d;
      last_int_q <= last_int_d;
      state_q    <= state_d;
      vcnt_q     <= vcnt_d;
      hit_flag_q <= hit_flag_d;
      hit_cnt_q  <= hit_cnt_d;
      enable_q   <= enable_d;
      irq_en_q   <= irq_en_d;
      prdata_q   <= prdata_d;
    end
  end

endmodule

// File: tb/tb_fire_rx.sv
// tb_fire_rx: directed bench for fire_rx with an APB read scoreboard.
// Latency: fixed-length sequence, no open-ended waits.
// Backpressure: n/a (DUT PREADY tied high).
module tb_fire_rx;

  // Timing scaled down from the nominal carrier so long sequences stay short.
  localparam int PER  = 16;
  localparam int TOLC = 2;
  localparam int HITN = 8;
  localparam int GAPC = 48;
  localparam int HIGH = 8;
  localparam int BAD  = 19;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic [31:0] PADDR = 32'd0;
  logic [31:0] PWDATA = 32'd0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic        ir_in = 1'b0;
  logic        hit_irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  fire_rx #(
    .PERIOD(PER), .TOL(TOLC), .HIT_PERIODS(HITN), .GAP(GAPC)
  ) u_dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .ir_in(ir_in), .hit_irq(hit_irq)
  );

  always #5 PCLK = ~PCLK;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge PCLK);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input int r, input logic [31:0] d);
    PADDR = 32'h700 | (r << 2);
    PWDATA = d;
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0;
    tick(1);
    PENABLE = 1'b1;
    tick(1);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  // Expected value is queued at issue and popped when PRDATA is valid.
  task automatic apb_read(input string tag, input int r, input logic [31:0] exp);
    logic [31:0] e;
    exp_q.push_back(exp);
    PADDR = 32'h700 | (r << 2);
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0;
    tick(1);
    PENABLE = 1'b1;
    tick(1);
    PSEL = 1'b0; PENABLE = 1'b0;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, PRDATA);
    end else begin
      e = exp_q.pop_front();
      check(tag, PRDATA, e);
    end
  endtask

  task automatic ir_periods(input int n, input int per);
    repeat (n) begin
      ir_in = 1'b1;
      tick(HIGH);
      ir_in = 1'b0;
      tick(per - HIGH);
    end
  endtask

  // One nominal period whose rise reaches the FSM on the same edge as an APB write.
  task automatic rise_with_write(input int r, input logic [31:0] d);
    ir_in = 1'b1;
    tick(1);
    PADDR = 32'h700 | (r << 2);
    PWDATA = d;
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0;
    tick(1);
    PENABLE = 1'b1;
    tick(1);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    tick(HIGH - 3);
    ir_in = 1'b0;
    tick(PER - HIGH);
  endtask

  initial begin
    // Reset state
    tick(3);
    PRESET = 1'b0;
    check("rst_prdata", PRDATA, 32'd0);
    check("rst_irq", {31'd0, hit_irq}, 32'd0);
    check("pready", {31'd0, PREADY}, 32'd1);
    check("pslverr", {31'd0, PSLVERR}, 32'd0);
    apb_read("rst_reg0", 0, 32'h20);
    apb_read("rst_reg1", 1, 32'd0);
    apb_read("rst_reg2", 2, 32'd0);
    apb_read("rst_reg3", 3, 32'd0);
    tick(1);
    check("prdata_idle", PRDATA, 32'd0);

    // Nominal burst: hit after the 8th valid period, once only
    apb_write(0, 32'h6);
    ir_periods(8, PER);
    check("no_hit_7_valid", {31'd0, hit_irq}, 32'd0);
    ir_periods(1, PER);
    check("hit_8_valid", {31'd0, hit_irq}, 32'd1);
    ir_periods(3, PER);
    apb_read("burst_count", 1, 32'd1);
    apb_read("burst_last_int", 2, PER);
    apb_read("lockout_reg0", 0, 32'h37);
    tick(60);
    apb_read("idle_reg0", 0, 32'h23);
    apb_write(0, 32'h7);
    check("w1c_irq_low", {31'd0, hit_irq}, 32'd0);

    // Off-frequency carrier: tracked but never a hit
    ir_periods(20, BAD);
    check("bad_no_hit", {31'd0, hit_irq}, 32'd0);
    apb_read("bad_count", 1, 32'd1);
    apb_read("bad_last_int", 2, BAD);
    apb_read("bad_track", 0, 32'h2E);
    tick(10);
    apb_read("bad_track_held", 0, 32'h2E);
    tick(40);
    apb_read("bad_gap_idle", 0, 32'h22);

    // Burst separation shorter / longer than the gap
    apb_write(1, 32'd0);
    apb_read("cnt_cleared", 1, 32'd0);
    ir_periods(12, PER);
    check("sep_hit_a", {31'd0, hit_irq}, 32'd1);
    tick(24);
    ir_periods(12, PER);
    tick(80);
    apb_read("short_sep", 1, 32'd1);
    ir_periods(12, PER);
    tick(80);
    apb_read("long_sep", 1, 32'd2);

    // Hit coinciding with W1C clear: set wins
    apb_write(0, 32'h7);
    check("pre_coinc_irq", {31'd0, hit_irq}, 32'd0);
    ir_periods(8, PER);
    rise_with_write(0, 32'h7);
    check("set_beats_clr", {31'd0, hit_irq}, 32'd1);
    apb_read("coinc_count", 1, 32'd3);
    tick(80);
    apb_write(0, 32'h2);
    check("irq_masked", {31'd0, hit_irq}, 32'd0);
    apb_read("masked_reg0", 0, 32'h21);

    // Hit coinciding with count clear: result 1
    ir_periods(8, PER);
    rise_with_write(1, 32'd0);
    apb_read("clr_plus_hit", 1, 32'd1);
    tick(80);

    // Disabled: no hit, interval capture still runs
    apb_write(0, 32'h1);
    ir_periods(12, PER);
    apb_read("dis_reg0", 0, 32'h00);
    apb_read("dis_count", 1, 32'd1);
    apb_read("dis_last_int", 2, PER);

    // Saturation of hit_count
    apb_write(1, 32'd0);
    for (int i = 0; i < 260; i++) begin
      apb_write(0, 32'h2);
      ir_periods(9, PER);
      apb_write(0, 32'h0);
    end
    apb_read("sat_count", 1, 32'd255);
    apb_write(1, 32'd0);
    apb_read("sat_cleared", 1, 32'd0);

    // Reset mid-burst discards progress
    apb_write(0, 32'h6);
    ir_periods(6, PER);
    PRESET = 1'b1;
    tick(1);
    PRESET = 1'b0;
    check("midrst_irq", {31'd0, hit_irq}, 32'd0);
    check("midrst_prdata", PRDATA, 32'd0);
    apb_read("midrst_reg0", 0, 32'h20);
    apb_read("midrst_reg1", 1, 32'd0);
    apb_read("midrst_reg2", 2, 32'd0);
    apb_write(0, 32'h6);
    ir_periods(8, PER);
    check("midrst_no_early", {31'd0, hit_irq}, 32'd0);
    ir_periods(1, PER);
    check("midrst_hit", {31'd0, hit_irq}, 32'd1);
    apb_read("midrst_count", 1, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fire_rx.md
FIRE_RX -- requirements
Module: fire_rx

Interface
REQ-001 SHALL have parameter PERIOD, default 1317, nominal carrier period in PCLK cycles between rising edges.
REQ-002 SHALL have parameter TOL, default 64, allowed +/- deviation of a measured period in cycles.
REQ-003 SHALL have parameter HIT_PERIODS, default 8, consecutive valid periods required to declare a hit.
REQ-004 SHALL have parameter GAP, default 3951, carrier-absent cycles that end a burst.
REQ-005 SHALL have port PCLK, input, 1, the single clock; all logic is rising-edge PCLK.
REQ-006 SHALL have port PRESET, input, 1, synchronous active-high reset.
REQ-007 SHALL have ports PSEL, PENABLE, PWRITE, input, 1 each, APB select, access phase and write strobe.
REQ-008 SHALL have port PADDR, input, 32, APB address; block selected when PADDR[11:8]==7; register is PADDR[3:2].
REQ-009 SHALL have port PWDATA, input, 32, APB write data.
REQ-010 SHALL have port PRDATA, output, 32, registered APB read data.
REQ-011 SHALL have ports PREADY, output, 1, tied 1, and PSLVERR, output, 1, tied 0.
REQ-012 SHALL have port ir_in, input, 1, asynchronous carrier-modulated IR sensor signal.
REQ-013 SHALL have port hit_irq, output, 1, level interrupt, high while hit_flag is set and irq_en is 1.

Function
REQ-014 SHALL synchronize ir_in through two flops and detect rising edges on the synchronized signal (rise = 1 for one cycle).
REQ-015 SHALL keep a 13-bit interval counter: cleared to 1 on rise, otherwise incremented, saturating at 8191.
REQ-016 SHALL treat a rise as a valid period when PERIOD-TOL <= interval <= PERIOD+TOL, using the counter value before clearing.
REQ-017 SHALL capture the counter value on every rise into last_interval (13 bits).
REQ-018 SHALL implement states IDLE, TRACK, LOCKOUT with a 4-bit valid-period counter vcnt.
REQ-019 IDLE: on any rise, go to TRACK with vcnt=0; no other transition.
REQ-020 TRACK: valid rise increments vcnt; invalid rise sets vcnt=0; interval reaching GAP returns to IDLE.
REQ-021 TRACK: when a valid rise makes vcnt equal HIT_PERIODS, in that same cycle set hit_flag, increment hit_count, and go to LOCKOUT.
REQ-022 LOCKOUT: ignore rises for hit purposes; go to IDLE when interval reaches GAP, so one burst gives exactly one hit.
REQ-023 hit_count SHALL be 8 bits and saturate at 255.
REQ-024 carrier_present SHALL be 1 while state != IDLE.
REQ-025 When enable is 0, state SHALL be forced to IDLE and no hit registered; synchronizer and interval counter keep running.
REQ-026 APB write (PSEL&&PENABLE&&PWRITE, selected) reg 0: bit0=1 clears hit_flag (write-one-to-clear), bit1 sets enable, bit2 sets irq_en.
REQ-027 APB write reg 1: any write clears hit_count to 0.
REQ-028 Hit set and W1C clear in the same cycle: set SHALL win; hit increment and count clear in the same cycle: result SHALL be 1.
REQ-029 PRDATA SHALL update one cycle after PSEL&&!PWRITE and be 0 otherwise.
REQ-030 PRDATA reg 0 = {27'b0, state[1:0], carrier_present, irq_en, hit_flag}, with enable reflected in bit 5; reg 1 = {24'b0, hit_count}; reg 2 = {19'b0, last_interval}; reg 3 = 0.

Reset
REQ-031 PRESET=1 at a PCLK edge SHALL set state IDLE, vcnt 0, interval 0, last_interval 0, hit_flag 0, hit_count 0, enable 1, irq_en 0, synchronizer flops 0, PRDATA 0, hit_irq 0.
REQ-032 Reset mid-burst SHALL discard progress; after release a full HIT_PERIODS of valid periods is needed for a hit.

Verification
REQ-033 Enabled, drive 12 periods of 1317 cycles (658 high) -> hit_flag=1 after the 8th valid rise following the first; hit_count=1; one hit only.
REQ-034 Period 1500 cycles for 20 periods -> no hit; reg 2 reads 1500; state TRACK until 3951 idle cycles, then IDLE.
REQ-035 Two bursts separated by 2000 idle cycles -> hit_count=1; separated by 5000 idle cycles -> hit_count=2.
REQ-036 irq_en=1, hit -> hit_irq=1; write reg0=0x1 -> hit_irq=0 next cycle; hit coinciding with the clear -> hit_flag stays 1.
REQ-037 Force 260 hits -> hit_count=255; write reg1 -> reads 0.
REQ-038 PRESET pulse at 5th valid period -> all registers at reset values; hit only after 8 further valid periods.
